// File: rtl/ball_motion.sv
// ball_motion -- per-frame motion engine for the bouncing-balls design.
//
// On each accepted frame tick the engine steps a working border margin, then
// walks every ball through a CALC (candidate position) and a WRITE (clamp to
// the border and write back) cycle, and finally commits all working values to
// the outputs in a single cycle, so the renderer never sees a half-updated
// frame. Ticks that arrive while an update is running (including the commit
// cycle) are dropped.
//
// Optional feature macro: MARGIN_ANIM_EN
//   defined   - the border breathes 0..MARGIN_MAX..0, one pixel per frame
//   undefined - the border stays at 0 (full-screen bounds); the MARGIN state
//               still takes one cycle so the frame latency does not change
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   ftick      in   one-cycle frame tick from the vga stage
//   margin     out  committed border width in pixels
//   ball_x     out  committed left edges, ball i at [10*i+9:10*i]
//   ball_y     out  committed top edges, same packing as ball_x
//   busy       out  high while an update is in progress
//   frame_done out  one-cycle pulse when new values are committed
module ball_motion #(
  parameter int NBALLS     = 4,
  parameter int BALL_SIZE  = 16,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SPEED      = 2,
  parameter int MARGIN_MAX = 80
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ftick,
  output logic [9:0]             margin,
  output logic [10*NBALLS-1:0]   ball_x,
  output logic [10*NBALLS-1:0]   ball_y,
  output logic                   busy,
  output logic                   frame_done
);

  // Reject parameter sets the clamp arithmetic cannot represent.
  if ((NBALLS < 1) || (NBALLS > 4) || (2 * MARGIN_MAX >= V_RES - BALL_SIZE)) begin : g_bad_params
    $error("ball_motion: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MARGIN = 3'd1,
    S_CALC   = 3'd2,
    S_WRITE  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [1:0]         idx_r;
  logic               last_s;
  logic [9:0]         wm_s;          // working margin for the current frame
  logic [9:0]         x_r  [NBALLS];
  logic [9:0]         y_r  [NBALLS];
  logic               dx_r [NBALLS];  // 1 = moving right
  logic               dy_r [NBALLS];  // 1 = moving down
  logic signed [10:0] cx_r;
  logic signed [10:0] cy_r;
  logic signed [10:0] lo_s;
  logic signed [10:0] xhi_s;
  logic signed [10:0] yhi_s;
  logic [9:0]         nx_s;
  logic [9:0]         ny_s;
  logic               ndx_s;
  logic               ndy_s;

  function automatic logic [9:0] init_x(input int i);
    init_x = 10'd100 + 10'd120 * 10'(i);
  endfunction

  function automatic logic [9:0] init_y(input int i);
    init_y = 10'd60 + 10'd80 * 10'(i);
  endfunction

  function automatic logic init_dx(input int i);
    init_dx = ((i % 2) == 0);
  endfunction

  function automatic logic init_dy(input int i);
    init_dy = (i < 2);
  endfunction

  assign last_s = (idx_r == 2'(NBALLS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ticks are only accepted in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ftick) begin
          state_s = S_MARGIN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MARGIN: state_s = S_CALC;
      S_CALC:   state_s = S_WRITE;
      S_WRITE: begin
        if (last_s) begin
          state_s = S_COMMIT;
        end else begin
          state_s = S_CALC;
        end
      end
      S_COMMIT: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

`ifdef MARGIN_ANIM_EN
  logic [9:0] wm_r;
  logic       shrink_r;

  // Border breathing: the turning value is held for one frame because the
  // direction flips on the same step that reaches it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wm_r     <= 10'd0;
      shrink_r <= 1'b0;
    end else if (state_r == S_MARGIN) begin
      if (shrink_r) begin
        wm_r <= wm_r - 10'd1;
        if (wm_r == 10'd1) begin
          shrink_r <= 1'b0;
        end
      end else begin
        wm_r <= wm_r + 10'd1;
        if (wm_r == 10'(MARGIN_MAX - 1)) begin
          shrink_r <= 1'b1;
        end
      end
    end
  end

  assign wm_s = wm_r;
`else
  assign wm_s = 10'd0;
`endif

  // Clamp the candidate of the current ball against this frame's border.
  always_comb begin
    lo_s  = $signed({1'b0, wm_s});
    xhi_s = $signed(11'(H_RES - BALL_SIZE)) - lo_s;
    yhi_s = $signed(11'(V_RES - BALL_SIZE)) - lo_s;
    nx_s  = cx_r[9:0];
    ndx_s = dx_r[idx_r];
    ny_s  = cy_r[9:0];
    ndy_s = dy_r[idx_r];
    if (cx_r > xhi_s) begin
      nx_s  = xhi_s[9:0];
      ndx_s = 1'b0;
    end else if (cx_r < lo_s) begin
      nx_s  = lo_s[9:0];
      ndx_s = 1'b1;
    end else begin
      nx_s  = cx_r[9:0];
      ndx_s = dx_r[idx_r];
    end
    if (cy_r > yhi_s) begin
      ny_s  = yhi_s[9:0];
      ndy_s = 1'b0;
    end else if (cy_r < lo_s) begin
      ny_s  = lo_s[9:0];
      ndy_s = 1'b1;
    end else begin
      ny_s  = cy_r[9:0];
      ndy_s = dy_r[idx_r];
    end
  end

  // Working ball state: candidate computation in CALC, write-back in WRITE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_r <= 2'd0;
      cx_r  <= 11'sd0;
      cy_r  <= 11'sd0;
      for (int i = 0; i < NBALLS; i++) begin
        x_r[i]  <= init_x(i);
        y_r[i]  <= init_y(i);
        dx_r[i] <= init_dx(i);
        dy_r[i] <= init_dy(i);
      end
    end else begin
      case (state_r)
        S_MARGIN: idx_r <= 2'd0;
        S_CALC: begin
          if (dx_r[idx_r]) begin
            cx_r <= $signed({1'b0, x_r[idx_r]}) + $signed(11'(SPEED));
          end else begin
            cx_r <= $signed({1'b0, x_r[idx_r]}) - $signed(11'(SPEED));
          end
          if (dy_r[idx_r]) begin
            cy_r <= $signed({1'b0, y_r[idx_r]}) + $signed(11'(SPEED));
          end else begin
            cy_r <= $signed({1'b0, y_r[idx_r]}) - $signed(11'(SPEED));
          end
        end
        S_WRITE: begin
          x_r[idx_r]  <= nx_s;
          y_r[idx_r]  <= ny_s;
          dx_r[idx_r] <= ndx_s;
          dy_r[idx_r] <= ndy_s;
          idx_r       <= idx_r + 2'd1;
        end
        default: idx_r <= idx_r;
      endcase
    end
  end

  // Committed outputs: all fields change together in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      margin     <= 10'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NBALLS; i++) begin
        ball_x[10*i +: 10] <= init_x(i);
        ball_y[10*i +: 10] <= init_y(i);
      end
    end else begin
      busy       <= (state_s != S_IDLE);
      frame_done <= (state_r == S_COMMIT);
      if (state_r == S_COMMIT) begin
        margin <= wm_s;
        for (int i = 0; i < NBALLS; i++) begin
          ball_x[10*i +: 10] <= x_r[i];
          ball_y[10*i +: 10] <= y_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed vector table, hand-written
// multi-cycle sequences, and a randomized tick/reset run against a
// frame-level reference model.
module tb_ball_motion;
  localparam int N = 4;
  localparam int LAT = 2 + 2 * N;
  localparam int MMAX = 80;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ftick;
  logic [9:0]       margin;
  logic [10*N-1:0]  ball_x;
  logic [10*N-1:0]  ball_y;
  logic             busy;
  logic             frame_done;

  always #5 clk = ~clk;

  ball_motion #(.NBALLS(N)) dut (
    .clk(clk), .reset_n(reset_n), .ftick(ftick), .margin(margin),
    .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: whole-frame arithmetic on plain integers.
  int mk;
  int mx [N];
  int my [N];
  int mdx [N];
  int mdy [N];

  function automatic int model_margin(input int k);
`ifdef MARGIN_ANIM_EN
    int p;
    p = k % (2 * MMAX);
    return (p <= MMAX) ? p : (2 * MMAX - p);
`else
    return k - k;
`endif
  endfunction

  task automatic model_reset();
    mk = 0;
    for (int i = 0; i < N; i++) begin
      mx[i]  = 100 + 120 * i;
      my[i]  = 60 + 80 * i;
      mdx[i] = (i % 2 == 0) ? 1 : -1;
      mdy[i] = (i < 2) ? 1 : -1;
    end
  endtask

  task automatic model_frame();
    int m, xmax, ymax, c;
    mk++;
    m = model_margin(mk);
    xmax = 640 - 16 - m;
    ymax = 480 - 16 - m;
    for (int i = 0; i < N; i++) begin
      c = mx[i] + 2 * mdx[i];
      if (c > xmax) begin mx[i] = xmax; mdx[i] = -1; end
      else if (c < m) begin mx[i] = m; mdx[i] = 1; end
      else mx[i] = c;
      c = my[i] + 2 * mdy[i];
      if (c > ymax) begin my[i] = ymax; mdy[i] = -1; end
      else if (c < m) begin my[i] = m; mdy[i] = 1; end
      else my[i] = c;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_margin"}, 32'(margin), model_margin(mk));
    for (int b = 0; b < N; b++) begin
      check($sformatf("%s_x%0d", tag, b), 32'(ball_x[10*b +: 10]), mx[b]);
      check($sformatf("%s_y%0d", tag, b), 32'(ball_y[10*b +: 10]), my[b]);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    ftick = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Pulse one tick, wait (bounded) for the commit, and return the latency.
  task automatic run_frame(output int lat);
    ftick = 1'b1;
    @(posedge clk); #1;
    ftick = 1'b0;
    lat = 0;
    while (!frame_done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!frame_done) check("frame_timeout", 32'(frame_done), 32'd1);
    model_frame();
  endtask

  task automatic run_frames(input int n);
    int lat;
    for (int f = 0; f < n; f++) run_frame(lat);
  endtask

  typedef struct {
    int frames;
    int ball;
    int ex;
    int ey;
    int em;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, fd_cnt, remain, t;
    logic exp_fd;

    reset_n = 1'b0;
    ftick = 1'b0;

`ifdef MARGIN_ANIM_EN
    vecs.push_back('{0,  0, 100, 60,  0});
    vecs.push_back('{0,  3, 460, 300, 0});
    vecs.push_back('{1,  0, 102, 62,  1});
    vecs.push_back('{1,  1, 218, 142, 1});
    vecs.push_back('{1,  2, 342, 218, 1});
    vecs.push_back('{74, 1, 74,  288, 74});
    vecs.push_back('{75, 1, 76,  290, 75});
    vecs.push_back('{80, 1, 86,  300, 80});
    vecs.push_back('{81, 1, 88,  302, 79});
    vecs.push_back('{82, 1, 90,  304, 78});
`else
    vecs.push_back('{0,   0, 100, 60,  0});
    vecs.push_back('{1,   0, 102, 62,  0});
    vecs.push_back('{1,   1, 218, 142, 0});
    vecs.push_back('{1,   3, 458, 298, 0});
    vecs.push_back('{74,  1, 72,  288, 0});
    vecs.push_back('{150, 3, 160, 0,   0});
    vecs.push_back('{151, 3, 158, 0,   0});
    vecs.push_back('{152, 3, 156, 2,   0});
`endif

    // Reset values, then single-frame latency.
    do_reset(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_x3", 32'(ball_x[39:30]), 32'd460);
    compare_model("rst");
    run_frame(lat);
    check("latency", lat, LAT);
    check("fd_after_commit", 32'(frame_done), 32'd1);
    compare_model("frame1");

    // Directed vector table.
    foreach (vecs[v]) begin
      do_reset(2);
      run_frames(vecs[v].frames);
      check($sformatf("vec%0d_x", v), 32'(ball_x[10*vecs[v].ball +: 10]), vecs[v].ex);
      check($sformatf("vec%0d_y", v), 32'(ball_y[10*vecs[v].ball +: 10]), vecs[v].ey);
      check($sformatf("vec%0d_margin", v), 32'(margin), vecs[v].em);
      compare_model($sformatf("vec%0d", v));
    end

    // Second tick 4 cycles into an update is dropped.
    do_reset(2);
    ftick = 1'b1; @(posedge clk); #1; ftick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ftick = 1'b1; @(posedge clk); #1; ftick = 1'b0;
    fd_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (frame_done) fd_cnt++;
    end
    check("drop_fd_count", fd_cnt, 1);
    model_frame();
    compare_model("drop");

    // Reset while ball 2 is being calculated.
    do_reset(2);
    ftick = 1'b1; @(posedge clk); #1; ftick = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1;
    model_reset();
    fd_cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (frame_done) fd_cnt++;
    end
    check("midrst_fd_count", fd_cnt, 0);
    check("midrst_busy", 32'(busy), 32'd0);
    compare_model("midrst");

    // Randomized ticks and occasional resets against the model.
    do_reset(2);
    remain = 0;
    for (int c = 0; c < 4000; c++) begin
      t = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ftick = t[0];
      exp_fd = 1'b0;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        remain = 0;
      end else begin
        @(posedge clk); #1;
        if (remain == 0) begin
          if (t != 0) remain = LAT;
        end else begin
          remain--;
          if (remain == 0) begin
            model_frame();
            exp_fd = 1'b1;
          end
        end
      end
      check("rnd_fd", 32'(frame_done), 32'(exp_fd));
      check("rnd_busy", 32'(busy), (remain != 0) ? 32'd1 : 32'd0);
      compare_model("rnd");
    end
    ftick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
